// File: rtl/image_load_ctrl.sv
// image_load_ctrl
// ---------------------------------------------------------------------------
// Loads an image arriving from the UART receiver into the picture BRAM
// through write port A. The block waits for a start byte. It then packs each
// R, G, B byte triple into one 18-bit pixel, using the top 6 bits of each
// colour. Pixels are written at consecutive row-major addresses. A stalled
// upload is aborted by an inter-byte timeout, so a partial frame is never
// flagged as loaded.
//
// Ports
//   clk      in   1   base clock, also the BRAM port A clock
//   resetn   in   1   asynchronous active-low reset (release synchronised)
//   rx_byte  in   8   received UART byte, valid while rx_flag=1
//   rx_flag  in   1   one-cycle pulse, new rx_byte available
//   wr_en    out  1   BRAM write enable, one pulse per pixel
//   wr_addr  out  19  BRAM write address, 0 .. H_SIZE*V_SIZE-1
//   wr_data  out  18  pixel {R[7:2], G[7:2], B[7:2]}
//   busy     out  1   transfer in progress
//   loaded   out  1   complete frame stored
//   error    out  1   last transfer aborted by timeout (sticky)
// ---------------------------------------------------------------------------
module image_load_ctrl #(
    parameter int         H_SIZE         = 607,
    parameter int         V_SIZE         = 455,
    parameter logic [7:0] START_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_byte,
    input  logic        rx_flag,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [17:0] wr_data,
    output logic        busy,
    output logic        loaded,
    output logic        error
);

    localparam int                CNT_W        = $clog2(TIMEOUT_CYCLES);
    localparam logic [18:0]       LAST_ADDR    = 19'(H_SIZE * V_SIZE - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t           state;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_next;
    logic [1:0]       rst_sync;
    logic             rst_n_int;

    // Reset asserts immediately and releases only after two clock edges.
    // This keeps the release clean with respect to clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int     = rst_sync[1];
    assign idle_cnt_next = idle_cnt + CNT_W'(1);

    // Whole sequencer in one block, so every output is a register.
    // wr_data doubles as the pixel assembly register. Each colour field is
    // filled as its byte arrives, and the full pixel is stable in the WRITE
    // cycle.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            idle_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            loaded   <= 1'b0;
            error    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (rx_flag && rx_byte == START_BYTE) begin
                        state    <= RECV;
                        wr_addr  <= '0;
                        byte_idx <= 2'd0;
                        idle_cnt <= '0;
                        loaded   <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                RECV: begin
                    if (rx_flag) begin
                        idle_cnt <= '0;
                        case (byte_idx)
                            2'd0: begin
                                wr_data[17:12] <= rx_byte[7:2];
                                byte_idx       <= 2'd1;
                            end
                            2'd1: begin
                                wr_data[11:6] <= rx_byte[7:2];
                                byte_idx      <= 2'd2;
                            end
                            default: begin
                                wr_data[5:0] <= rx_byte[7:2];
                                byte_idx     <= 2'd0;
                                wr_en        <= 1'b1;
                                state        <= WRITE;
                            end
                        endcase
                    // Abort on the edge where the counter would reach its
                    // limit. A byte arriving on that same edge takes the
                    // branch above, so the byte wins the race.
                    end else if (idle_cnt_next == TIMEOUT_LAST) begin
                        state    <= IDLE;
                        idle_cnt <= '0;
                        error    <= 1'b1;
                        loaded   <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt_next;
                    end
                end

                WRITE: begin
                    idle_cnt <= '0;
                    if (wr_addr == LAST_ADDR) begin
                        state  <= DONE;
                        loaded <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        wr_addr <= wr_addr + 19'd1;
                        state   <= RECV;
                        // A byte that arrives unexpectedly during the write
                        // is kept as the red byte of the next pixel.
                        if (rx_flag) begin
                            wr_data[17:12] <= rx_byte[7:2];
                            byte_idx       <= 2'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_load_ctrl.sv
// tb_image_load_ctrl
// ---------------------------------------------------------------------------
// Self-checking bench for image_load_ctrl with a small 4x2 frame and a
// 100-cycle timeout. Expected behaviour comes from an event-level model.
// The model collects bytes into pixels and tracks a timeout deadline as an
// absolute cycle number. On top of that the bench uses a constant vector
// table and hand sequences for the multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_image_load_ctrl;

    localparam int         H_SIZE  = 4;
    localparam int         V_SIZE  = 2;
    localparam int         TO      = 100;
    localparam int         FRAME   = H_SIZE * V_SIZE;
    localparam logic [7:0] START   = 8'hA5;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  rx_byte;
    logic        rx_flag;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [17:0] wr_data;
    logic        busy;
    logic        loaded;
    logic        error;

    image_load_ctrl #(
        .H_SIZE         (H_SIZE),
        .V_SIZE         (V_SIZE),
        .START_BYTE     (START),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .rx_byte (rx_byte),
        .rx_flag (rx_flag),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .loaded  (loaded),
        .error   (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_count = 0;

    // Reference model state, kept at the level of bytes, pixels and cycle
    // deadlines.
    logic        m_active;
    logic        m_loaded;
    logic        m_error;
    logic [7:0]  m_part[$];
    int          m_pix;
    int          m_deadline;
    logic        m_finish_pending;
    int          m_finish_at;
    logic        m_exp_wr;
    logic [18:0] m_exp_addr;
    logic [17:0] m_exp_data;

    typedef struct {
        logic        flag;
        logic [7:0]  data;
        logic        e_wr;
        logic        e_busy;
        logic        e_loaded;
        logic        e_err;
        logic [18:0] e_addr;
        logic [17:0] e_data;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        m_active         = 1'b0;
        m_loaded         = 1'b0;
        m_error          = 1'b0;
        m_part.delete();
        m_pix            = 0;
        m_deadline       = 0;
        m_finish_pending = 1'b0;
        m_finish_at      = 0;
        m_exp_wr         = 1'b0;
        m_exp_addr       = '0;
        m_exp_data       = '0;
    endtask

    // One sampling edge c, with the byte (if any) seen on it.
    // A byte must arrive no later than the deadline edge. The deadline is
    // TO-1 edges after a byte, or TO edges after a pixel-completing byte,
    // because the write cycle does not count as idle.
    task automatic modelStep(input int c, input logic f, input logic [7:0] b);
        logic [7:0] p0, p1, p2;
        m_exp_wr = 1'b0;
        if (m_finish_pending && c == m_finish_at) begin
            m_finish_pending = 1'b0;
            m_active         = 1'b0;
            m_loaded         = 1'b1;
            return;
        end
        if (!m_active) begin
            if (f && b == START) begin
                m_active   = 1'b1;
                m_loaded   = 1'b0;
                m_error    = 1'b0;
                m_pix      = 0;
                m_part.delete();
                m_deadline = c + TO - 1;
            end
        end else if (f) begin
            m_part.push_back(b);
            if (m_part.size() == 3) begin
                p0 = m_part[0];
                p1 = m_part[1];
                p2 = m_part[2];
                m_part.delete();
                m_exp_wr   = 1'b1;
                m_exp_addr = 19'(m_pix);
                m_exp_data = {p0[7:2], p1[7:2], p2[7:2]};
                m_pix++;
                if (m_pix == FRAME) begin
                    m_finish_pending = 1'b1;
                    m_finish_at      = c + 1;
                end else begin
                    m_deadline = c + TO;
                end
            end else begin
                m_deadline = c + TO - 1;
            end
        end else if (!m_finish_pending && c == m_deadline) begin
            m_active = 1'b0;
            m_error  = 1'b1;
            m_loaded = 1'b0;
        end
    endtask

    task automatic driveCycle(input logic f, input logic [7:0] b);
        rx_flag = f;
        rx_byte = f ? b : 8'($urandom);
        @(negedge clk);
        cyc++;
        modelStep(cyc, f, b);
        if (wr_en === 1'b1) wr_count++;
    endtask

    task automatic checkOutput();
        check("wr_en", 32'(wr_en), 32'(m_exp_wr));
        if (m_exp_wr) begin
            check("wr_addr", 32'(wr_addr), 32'(m_exp_addr));
            check("wr_data", 32'(wr_data), 32'(m_exp_data));
        end
        check("busy", 32'(busy), 32'(m_active));
        check("loaded", 32'(loaded), 32'(m_loaded));
        check("error", 32'(error), 32'(m_error));
    endtask

    task automatic applyStimulus(input logic f, input logic [7:0] b);
        driveCycle(f, b);
        checkOutput();
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        applyStimulus(1'b1, b);
        repeat (gap) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_loaded"}, 32'(loaded), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gap;
        logic [7:0] b;

        // Idle noise, start byte and first pixel of the frame test.
        vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 18'd0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 18'd0};
        vecs[2]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 18'd0};
        vecs[3]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 18'd0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 18'd0};
        vecs[5]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0, 18'd0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0, 18'd0};
        vecs[7]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0, 18'd0};
        vecs[8]  = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0, 18'd0};
        vecs[9]  = '{1'b1, 8'hFC, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 18'h0483F};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 19'd1, 18'd0};

        modelReset();
        resetn  = 1'b0;
        rx_flag = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        resetn = 1'b1;
        repeat (3) applyStimulus(1'b0, 8'h00);

        // Table-driven vectors.
        wr_count = 0;
        foreach (vecs[i]) begin
            driveCycle(vecs[i].flag, vecs[i].data);
            check($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_loaded", i), 32'(loaded), 32'(vecs[i].e_loaded));
            check($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].e_err));
            check($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].e_addr));
            if (vecs[i].e_wr) begin
                check($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].e_data));
            end
        end

        // Rest of the full frame, pixel k = (10+k, 80, FC).
        for (int k = 1; k < FRAME; k++) begin
            sendByte(8'(8'h10 + k), 2);
            sendByte(8'h80, 2);
            if (k < FRAME - 1) sendByte(8'hFC, 2);
        end
        applyStimulus(1'b1, 8'hFC);
        check("last_wr_en", 32'(wr_en), 32'd1);
        check("last_wr_addr", 32'(wr_addr), 32'(FRAME - 1));
        applyStimulus(1'b0, 8'h00);
        check("loaded_after_last", 32'(loaded), 32'd1);
        check("busy_after_last", 32'(busy), 32'd0);
        check("frame_writes", 32'(wr_count), 32'(FRAME));
        repeat (3) applyStimulus(1'b0, 8'h00);

        // Reload from DONE, then let it time out after 4 data bytes.
        wr_count = 0;
        applyStimulus(1'b1, START);
        check("reload_loaded_clear", 32'(loaded), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);
        repeat (2) applyStimulus(1'b0, 8'h00);
        sendByte(8'h11, 1);
        sendByte(8'h22, 1);
        applyStimulus(1'b1, 8'h33);
        check("reload_first_wr_en", 32'(wr_en), 32'd1);
        check("reload_first_addr", 32'(wr_addr), 32'd0);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h44);
        repeat (TO - 2) applyStimulus(1'b0, 8'h00);
        check("no_abort_before_limit", 32'(error), 32'd0);
        applyStimulus(1'b0, 8'h00);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_loaded", 32'(loaded), 32'd0);
        repeat (10) applyStimulus(1'b0, 8'h00);
        check("timeout_writes", 32'(wr_count), 32'd1);

        // Fresh start clears error; then a byte lands exactly on the limit.
        wr_count = 0;
        applyStimulus(1'b1, START);
        check("error_cleared", 32'(error), 32'd0);
        sendByte(8'h01, 1);
        sendByte(8'h02, 1);
        sendByte(8'h03, 1);
        applyStimulus(1'b1, 8'h04);
        repeat (TO - 2) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h05);
        check("race_no_abort", 32'(error), 32'd0);
        check("race_busy", 32'(busy), 32'd1);
        repeat (5) applyStimulus(1'b0, 8'h00);
        check("race_still_busy", 32'(busy), 32'd1);
        for (int j = 0; j < 3 * FRAME - 5; j++) sendByte(8'(8'h40 + j), 1);
        check("race_frame_loaded", 32'(loaded), 32'd1);
        check("race_frame_writes", 32'(wr_count), 32'(FRAME));

        // Reset in the middle of a frame, after three pixels.
        applyStimulus(1'b1, START);
        for (int j = 0; j < 9; j++) sendByte(8'(8'hC0 + j), 1);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rx_flag = 1'b0;
        #2 resetn = 1'b0;
        #1 checkAllZero("midreset");
        modelReset();
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        resetn = 1'b1;
        repeat (3) applyStimulus(1'b0, 8'h00);
        wr_count = 0;
        applyStimulus(1'b1, START);
        sendByte(8'h40, 1);
        sendByte(8'h50, 1);
        applyStimulus(1'b1, 8'h60);
        check("restart_wr_en", 32'(wr_en), 32'd1);
        check("restart_addr", 32'(wr_addr), 32'd0);
        repeat (3) applyStimulus(1'b0, 8'h00);

        // Random byte stream against the model, gaps straddling the timeout.
        for (int i = 0; i < 150; i++) begin
            b = ($urandom_range(0, 7) == 0) ? START : 8'($urandom);
            applyStimulus(1'b1, b);
            if ($urandom_range(0, 9) == 0) gap = $urandom_range(TO - 10, TO + 10);
            else gap = $urandom_range(0, 3);
            repeat (gap) applyStimulus(1'b0, 8'h00);
        end
        repeat (TO + 5) applyStimulus(1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_load_ctrl.md
# image_load_ctrl

Sequencer that loads a received image into the picture BRAM, write port A. It consumes the UART receiver's byte/flag output, waits for a start byte, then packs each group of three colour bytes into one 18-bit pixel. It writes pixels at consecutive raster addresses and raises `loaded` after the last pixel of an H_SIZE×V_SIZE frame. An inter-byte timeout aborts a stalled transfer, so a broken upload never leaves a half-written frame marked as valid.

## Interface
- `H_SIZE`, 607, image width in pixels
- `V_SIZE`, 455, image height in pixels
- `START_BYTE`, 8'hA5, command byte that opens a frame transfer
- `TIMEOUT_CYCLES`, 1_000_000, maximum idle clk cycles between bytes during a transfer (10 ms at 100 MHz)
- `clk  input  1  base clock (100 MHz), also the BRAM port A clock`
- `resetn  input  1  reset, asynchronous, active-low`
- `rx_byte  input  8  received byte from uart; valid only while rx_flag=1`
- `rx_flag  input  1  one-cycle pulse, new rx_byte available`
- `wr_en  output  1  BRAM port A write enable, one-cycle pulse per pixel`
- `wr_addr  output  19  BRAM write address, row-major, 0 .. H_SIZE*V_SIZE-1`
- `wr_data  output  18  pixel {R[7:2], G[7:2], B[7:2]}`
- `busy  output  1  transfer in progress (start byte accepted, frame not finished)`
- `loaded  output  1  complete frame stored`
- `error  output  1  last transfer aborted by timeout; sticky`

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - rx_flag with rx_byte==START_BYTE → RECV; clear addr, byte index, timeout counter, loaded and error.
  - Any other byte is ignored.
- RECV:
  - Byte index 0/1/2 = R/G/B. On each rx_flag, latch rx_byte[7:2] into the R, G or B field of the pixel register and advance the index.
  - When the third byte (B) is latched → WRITE.
  - In RECV, START_BYTE is treated as data; no escape mechanism.
- WRITE (exactly one cycle):
  - wr_en=1 with the current wr_addr and the packed wr_data. Byte index returns to 0.
  - If wr_addr == H_SIZE*V_SIZE-1 → DONE. Otherwise increment wr_addr → RECV.
- DONE:
  - loaded=1, busy=0.
  - rx_flag with START_BYTE → RECV (reload). This clears loaded the next cycle and resets wr_addr to 0.
  - Other bytes are ignored.
- Timeout:
  - In RECV, the counter increments every cycle without rx_flag and clears on rx_flag.
  - When the counter reaches TIMEOUT_CYCLES-1 → IDLE with error=1, loaded=0, busy=0. No further writes occur.
- Arithmetic:
  - wr_addr is a 19-bit unsigned counter. 607×455 = 276185 < 2^19.
  - The frame size constant is computed at elaboration time in 19 bits.
  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide.
- busy = state ∈ {RECV, WRITE}.

## Timing
- Reset values (asynchronous assertion; release synchronised internally to clk):
  - state=IDLE
  - wr_en=0, wr_addr=0, wr_data=0
  - busy=0, loaded=0, error=0
  - all counters 0
- All outputs are registered.
- Start byte:
  - Start byte on rx_flag in cycle n → busy=1 in n+1.
  - If accepted from DONE, loaded=0 in n+1.
- Pixel write:
  - Third byte of a pixel on rx_flag in cycle n → wr_en=1 in n+1, with wr_data/wr_addr stable in that same cycle.
  - wr_addr increments in n+2.
- Last pixel:
  - Write in cycle m → loaded=1 and busy=0 in m+1.
- rx_flag during WRITE cannot occur: the UART byte period is ≥100 cycles. If it does occur anyway, the byte is captured as byte index 0 of the next pixel and is not lost.
- Simultaneous events:
  - rx_flag in the same cycle the timeout counter reaches its limit → the byte wins. The counter clears and no abort occurs.
- Reset mid-transfer → immediate IDLE. The partial frame remains in BRAM but loaded=0.

## Test plan
Bench parameters: H_SIZE=4, V_SIZE=2, TIMEOUT_CYCLES=100.
- Full frame: send A5 then 24 bytes, pixel k = (8'h10+k, 8'h80, 8'hFC).
  - Expect 8 wr_en pulses at addr 0..7.
  - Expect wr_data for k=0 = {6'h04, 6'h20, 6'h3F}.
  - Expect loaded=1 one cycle after the write to addr 7; busy=0.
- Idle noise: bytes 00, FF, 5A before A5 → no wr_en, busy stays 0. The subsequent A5 starts the transfer normally.
- Timeout: A5 plus 4 bytes, then silence.
  - Expect exactly 1 write (addr 0).
  - Expect error=1 and busy=0 after 99 idle cycles, loaded=0.
  - A fresh A5 then clears error.
- Race: a byte arrives on exactly the cycle the timeout counter reaches 99 → no abort, the transfer continues.
- Reload: after loaded=1, send A5 → loaded=0 the next cycle, and the first pixel of the new frame is written to addr 0.
- Reset mid-frame: assert resetn=0 after 3 pixels → all outputs 0 asynchronously. After release, A5 restarts the transfer at addr 0.
